// File: rtl/param_dither_if.sv
// param_dither_if: host command registers (req/ack/busy, r0-r7) plus framebuffer write bus (de_*); master = host side, slave = dither engine
interface param_dither_if #(parameter int ADDR_W = 18);
  logic req, ack, busy;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic de_req, de_ack, de_rnw;
  logic [ADDR_W-1:0] de_addr;
  logic [3:0] de_nbyte;
  logic [31:0] de_w_data, de_r_data;
  modport master (
    output req, r0, r1, r2, r3, r4, r5, r6, r7, de_ack, de_r_data,
    input ack, busy, de_req, de_rnw, de_addr, de_nbyte, de_w_data
  );
  modport slave (
    input req, r0, r1, r2, r3, r4, r5, r6, r7, de_ack, de_r_data,
    output ack, busy, de_req, de_rnw, de_addr, de_nbyte, de_w_data
  );
endinterface

// File: rtl/param_dither.sv
// param_dither: fills rectangle r0..r3 with colour r4/r5 dithered (Floyd-Steinberg, or truncate when r6[0]) into byte-lane framebuffer; ports clk, rst, bus (slave: req/ack/busy + r0-r7 command, de_* write bus); define PARAM_DITHER_CLAMP_EN to clamp corrected colour instead of wrapping
module param_dither #(
  parameter int SCREEN_W = 640,
  parameter int R_BITS = 3,
  parameter int G_BITS = 3,
  parameter int B_BITS = 2,
  parameter int ADDR_W = 18
) (
  input logic clk,
  input logic rst,
  param_dither_if.slave bus
);
  localparam int XW = $clog2(SCREEN_W);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [15:0] x0, y0, x1, y1, x, y;
  logic [7:0] col [3];
  logic mode, start, bad, acc_px, last_x, last, first_row;
  logic [ADDR_W+1:0] a;
  logic [7:0] pix;
  logic [XW-1:0] xi, xm;
  logic unused;
  assign unused = ^{bus.r7, bus.r6[15:1], bus.r5[7:0], bus.de_r_data};
  assign start = state == IDLE && bus.req;
  assign bad = bus.r2 < bus.r0 || bus.r3 < bus.r1;
  assign acc_px = state == BUSY && bus.de_ack;
  assign last_x = x == x1;
  assign last = last_x && y == y1;
  assign first_row = y == y0;
  assign xi = x[XW-1:0];
  assign xm = XW'(x - 16'd1);
  assign a = (ADDR_W+2)'(32'(x) + 32'(y) * 32'(SCREEN_W));
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (start && !bad ? BUSY : IDLE) : (acc_px && last ? IDLE : BUSY);
  always_comb begin
    bus.ack = start && !rst;
    bus.busy = state == BUSY;
    bus.de_req = state == BUSY;
    bus.de_rnw = 1'b0;
    bus.de_addr = state == BUSY ? a[ADDR_W+1:2] : '0;
    bus.de_nbyte = state == BUSY ? ~(4'b0001 << a[1:0]) : 4'hf;
    bus.de_w_data = state == BUSY ? {4{pix}} : '0;
  end
  always_ff @(posedge clk)
    if (start) begin
      x0 <= bus.r0;
      y0 <= bus.r1;
      x1 <= bus.r2;
      y1 <= bus.r3;
      x <= bus.r0;
      y <= bus.r1;
      col[0] <= bus.r4[15:8];
      col[1] <= bus.r4[7:0];
      col[2] <= bus.r5[15:8];
      mode <= bus.r6[0];
    end else if (acc_px) begin
      x <= last_x ? x0 : x + 16'd1;
      y <= last_x ? y + 16'd1 : y;
    end
  for (genvar i = 0; i < 3; i++) begin : ch
    localparam int CB = i == 0 ? R_BITS : i == 1 ? G_BITS : B_BITS;
    localparam int SH = 8 - CB;
    logic signed [11:0] lb [SCREEN_W];
    logic signed [11:0] rt, p1, p2, acc, e12;
    logic signed [9:0] cf, e;
    logic [7:0] cv, q;
    logic [8:0] qr;
    logic unused_c;
    assign unused_c = ^cf[9:8];
    assign e12 = {{2{e[9]}}, e};
    always_comb begin
      acc = rt + (first_row ? 12'sd0 : lb[xi]);
      cf = $signed({2'b00, col[i]}) + (mode ? 10'sd0 : 10'((acc + 12'sd8) >>> 4));
`ifdef PARAM_DITHER_CLAMP_EN
      cv = cf < 10'sd0 ? 8'd0 : cf > 10'sd255 ? 8'd255 : cf[7:0];
`else
      cv = cf[7:0];
`endif
      qr = mode ? 9'(cv >> SH) : 9'(({1'b0, cv} + 9'(1 << (SH - 1))) >> SH);
      q = qr > 9'((1 << CB) - 1) ? 8'((1 << CB) - 1) : qr[7:0];
      e = $signed(10'(cv) - (10'(q) << SH));
    end
    // rt: 7/16 for the right neighbour; p1/p2: partial next-row sums for x-1 and x (in 1/16 units)
    always_ff @(posedge clk)
      if (rst || start) begin
        rt <= '0;
        p1 <= '0;
        p2 <= '0;
      end else if (acc_px) begin
        rt <= last_x ? '0 : e12 * 12'sd7;
        p1 <= last_x ? '0 : p2 + e12 * 12'sd5;
        p2 <= last_x ? '0 : e12;
      end
    // lb[x] is read for this row before being overwritten with the next row's total
    always_ff @(posedge clk)
      if (acc_px) begin
        if (x != x0) lb[xm] <= p1 + e12 * 12'sd3;
        if (last_x) lb[xi] <= p2 + e12 * 12'sd5;
      end
  end
  assign pix = (ch[0].q << (G_BITS + B_BITS)) | (ch[1].q << B_BITS) | ch[2].q;
endmodule

// File: tb/tb_param_dither.sv
// tb_param_dither: randomized self-checking bench for param_dither against a 2-D Floyd-Steinberg reference model
module tb_param_dither;
  localparam int SW = 640;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  param_dither_if #(.ADDR_W(18)) bus();
  param_dither #(.SCREEN_W(SW), .R_BITS(3), .G_BITS(3), .B_BITS(2), .ADDR_W(18)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int checks = 0;
  int failures = 0;
  int n_ack, n_req, n_busy, last_acc, low_cyc, bad_rnw;
  logic idle_busy;
  logic [17:0] got_a[$], exp_a[$];
  logic [3:0] got_nb[$], exp_nb[$];
  logic [31:0] got_d[$], exp_d[$];

  task automatic model(input int xs, ys, xe, ye, cr, cg, cb, md);
    int acc [3][8][16];
    int colr [3];
    int w, h;
    exp_a.delete();
    exp_nb.delete();
    exp_d.delete();
    if (xe < xs || ye < ys) return;
    w = xe - xs + 1;
    h = ye - ys + 1;
    colr = '{cr, cg, cb};
    foreach (acc[c, r, k]) acc[c][r][k] = 0;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        int pix, ad;
        pix = 0;
        for (int c = 0; c < 3; c++) begin
          int bits, sh, cv, q, e;
          bits = c == 2 ? 2 : 3;
          sh = 8 - bits;
          if (md != 0) begin
            cv = colr[c];
            q = cv / (1 << sh);
          end else begin
            cv = colr[c] + ((acc[c][yy][xx] + 8) >>> 4);
`ifdef PARAM_DITHER_CLAMP_EN
            cv = cv < 0 ? 0 : cv > 255 ? 255 : cv;
`else
            cv = cv & 255;
`endif
            q = (cv + (1 << (sh - 1))) / (1 << sh);
            if (q > (1 << bits) - 1) q = (1 << bits) - 1;
            e = cv - q * (1 << sh);
            if (xx + 1 < w) acc[c][yy][xx+1] += 7 * e;
            if (yy + 1 < h) begin
              if (xx > 0) acc[c][yy+1][xx-1] += 3 * e;
              acc[c][yy+1][xx] += 5 * e;
              if (xx + 1 < w) acc[c][yy+1][xx+1] += e;
            end
          end
          pix = pix * (1 << bits) + q;
        end
        ad = (xs + xx) + (ys + yy) * SW;
        exp_a.push_back(18'(ad / 4));
        exp_nb.push_back(4'hf ^ 4'(1 << (ad % 4)));
        exp_d.push_back({4{8'(pix)}});
      end
  endtask

  task automatic issue(input int xs, ys, xe, ye, cr, cg, cb, md, ackmode, kill_after, input bit hold);
    got_a.delete();
    got_nb.delete();
    got_d.delete();
    n_req = 0;
    last_acc = -1;
    low_cyc = -1;
    bad_rnw = 0;
    idle_busy = 1'b1;
    @(negedge clk);
    bus.r0 = 16'(xs);
    bus.r1 = 16'(ys);
    bus.r2 = 16'(xe);
    bus.r3 = 16'(ye);
    bus.r4 = {8'(cr), 8'(cg)};
    bus.r5 = {8'(cb), 8'($urandom)};
    bus.r6 = {15'($urandom), 1'(md)};
    bus.r7 = 16'($urandom);
    bus.req = 1;
    bus.de_ack = 1'($urandom);
    #1;
    n_ack = int'(bus.ack);
    n_busy = int'(bus.busy);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      bus.req = hold;
      bus.de_ack = ackmode == 0 ? 1'b1 : ackmode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (!bus.de_req) begin
        low_cyc = cyc;
        idle_busy = bus.busy;
        break;
      end
      n_ack += int'(bus.ack);
      n_busy += int'(bus.busy);
      n_req++;
      bad_rnw += int'(bus.de_rnw);
      if (bus.de_ack) begin
        got_a.push_back(bus.de_addr);
        got_nb.push_back(bus.de_nbyte);
        got_d.push_back(bus.de_w_data);
        last_acc = cyc;
        if (got_a.size() == kill_after) return;
      end
    end
    bus.req = 0;
    for (int cyc = 0; cyc < 300 && bus.busy; cyc++) begin
      @(negedge clk);
      bus.de_ack = 1;
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    bus.req = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.ack !== 1'b0 || bus.busy !== 1'b0 || bus.de_req !== 1'b0) begin
        failures++;
        $display("FAIL reset_ctl ack=%b busy=%b de_req=%b exp 0/0/0", bus.ack, bus.busy, bus.de_req);
      end
      checks++;
      if (bus.de_addr !== 18'd0 || bus.de_nbyte !== 4'hf || bus.de_w_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_bus addr=%h nb=%b data=%h exp 0/1111/0", bus.de_addr, bus.de_nbyte, bus.de_w_data);
      end
    end
    bus.req = 0;
    rst = 0;
  endtask

  task automatic test_truncate_single();
    issue(0, 0, 0, 0, 8'h80, 8'h80, 8'h80, 1, 0, 0, 0);
    checks++;
    if (n_ack !== 1 || got_a.size() !== 1) begin
      failures++;
      $display("FAIL single_count acks=%0d writes=%0d exp 1/1", n_ack, got_a.size());
    end
    if (got_a.size() > 0) begin
      checks++;
      if (got_a[0] !== 18'd0 || got_nb[0] !== 4'b1110 || got_d[0] !== 32'h92929292) begin
        failures++;
        $display("FAIL single_pix addr=%h nb=%b data=%h exp 0/1110/92929292", got_a[0], got_nb[0], got_d[0]);
      end
    end
    checks++;
    if (low_cyc !== last_acc + 1) begin
      failures++;
      $display("FAIL single_tail de_req low at %0d exp %0d", low_cyc, last_acc + 1);
    end
  endtask

  task automatic test_fs_block();
    for (int am = 0; am < 2; am++) begin
      model(0, 0, 3, 1, 8'h40, 8'h40, 8'h40, 0);
      issue(0, 0, 3, 1, 8'h40, 8'h40, 8'h40, 0, am, 0, 0);
      checks++;
      if (got_a.size() !== 8 || n_ack !== 1) begin
        failures++;
        $display("FAIL fs_block%0d_count writes=%0d acks=%0d exp 8/1", am, got_a.size(), n_ack);
      end
      for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
        checks++;
        if (got_a[i] !== exp_a[i] || got_nb[i] !== exp_nb[i] || got_d[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL fs_block%0d_pix%0d got %h/%b/%h exp %h/%b/%h", am, i, got_a[i], got_nb[i], got_d[i], exp_a[i], exp_nb[i], exp_d[i]);
        end
      end
      checks++;
      if (low_cyc !== last_acc + 1 || n_busy !== n_req || bad_rnw !== 0) begin
        failures++;
        $display("FAIL fs_block%0d_tail low=%0d exp %0d busy=%0d exp %0d rnw=%0d exp 0", am, low_cyc, last_acc + 1, n_busy, n_req, bad_rnw);
      end
    end
  endtask

  task automatic test_invalid();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue(5, 0, 2, 0, 8'h11, 8'h22, 8'h33, 0, 0, 0, 0);
      else issue(0, 5, 3, 2, 8'h11, 8'h22, 8'h33, 0, 0, 0, 0);
      checks++;
      if (n_ack !== 1 || n_req !== 0 || low_cyc !== 0 || idle_busy !== 1'b0 || got_a.size() !== 0) begin
        failures++;
        $display("FAIL invalid%0d acks=%0d req_cycles=%0d low=%0d busy=%b writes=%0d exp 1/0/0/0/0", k, n_ack, n_req, low_cyc, idle_busy, got_a.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    model(0, 0, 3, 1, 8'h40, 8'h40, 8'h40, 0);
    issue(0, 0, 3, 1, 8'h40, 8'h40, 8'h40, 0, 0, 3, 0);
    checks++;
    if (got_a.size() !== 3) begin
      failures++;
      $display("FAIL mid_prefix writes=%0d exp 3", got_a.size());
    end
    @(negedge clk);
    rst = 1;
    bus.req = 1;
    bus.de_ack = 1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.de_req !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 1'b0 || bus.de_nbyte !== 4'hf) begin
      failures++;
      $display("FAIL mid_reset de_req=%b busy=%b ack=%b nb=%b exp 0/0/0/1111", bus.de_req, bus.busy, bus.ack, bus.de_nbyte);
    end
    rst = 0;
    bus.req = 0;
    issue(0, 0, 3, 1, 8'h40, 8'h40, 8'h40, 0, 2, 0, 0);
    checks++;
    if (got_a.size() !== exp_a.size()) begin
      failures++;
      $display("FAIL mid_rerun_count writes=%0d exp %0d", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_a[i] || got_nb[i] !== exp_nb[i] || got_d[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL mid_rerun_pix%0d got %h/%b/%h exp %h/%b/%h", i, got_a[i], got_nb[i], got_d[i], exp_a[i], exp_nb[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_saturate();
    model(100, 7, 103, 8, 8'hff, 8'hff, 8'hff, 0);
    issue(100, 7, 103, 8, 8'hff, 8'hff, 8'hff, 0, 2, 0, 0);
    checks++;
    if (got_a.size() !== 8 || low_cyc !== last_acc + 1) begin
      failures++;
      $display("FAIL sat_count writes=%0d exp 8 low=%0d exp %0d", got_a.size(), low_cyc, last_acc + 1);
    end
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_a[i] || got_nb[i] !== exp_nb[i] || got_d[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL sat_pix%0d got %h/%b/%h exp %h/%b/%h", i, got_a[i], got_nb[i], got_d[i], exp_a[i], exp_nb[i], exp_d[i]);
      end
`ifdef PARAM_DITHER_CLAMP_EN
      checks++;
      if (got_d[i] !== 32'hffffffff) begin
        failures++;
        $display("FAIL sat_clamp_pix%0d data=%h exp ffffffff", i, got_d[i]);
      end
`endif
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int xs, ys, xe, ye, md;
      bit hold;
      xs = $urandom_range(0, 620);
      ys = $urandom_range(0, 200);
      xe = xs + $urandom_range(0, 9);
      ye = ys + $urandom_range(0, 4);
      md = $urandom_range(0, 3) == 0 ? 1 : 0;
      hold = 1'($urandom_range(0, 1));
      model(xs, ys, xe, ye, $urandom_range(0, 255), 0, 0, md);
      begin
        int cr, cg, cb;
        cr = $urandom_range(0, 255);
        cg = $urandom_range(0, 255);
        cb = $urandom_range(0, 255);
        model(xs, ys, xe, ye, cr, cg, cb, md);
        issue(xs, ys, xe, ye, cr, cg, cb, md, 2, 0, hold);
      end
      checks++;
      if (got_a.size() !== exp_a.size() || n_ack !== 1 || low_cyc !== last_acc + 1) begin
        failures++;
        $display("FAIL rand%0d_count writes=%0d exp %0d acks=%0d exp 1 low=%0d exp %0d", t, got_a.size(), exp_a.size(), n_ack, low_cyc, last_acc + 1);
      end
      for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
        checks++;
        if (got_a[i] !== exp_a[i] || got_nb[i] !== exp_nb[i] || got_d[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL rand%0d_pix%0d got %h/%b/%h exp %h/%b/%h", t, i, got_a[i], got_nb[i], got_d[i], exp_a[i], exp_nb[i], exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    bus.req = 0;
    bus.de_ack = 0;
    bus.de_r_data = '0;
    {bus.r0, bus.r1, bus.r2, bus.r3, bus.r4, bus.r5, bus.r6, bus.r7} = '0;
    test_reset();
    test_truncate_single();
    test_fs_block();
    test_invalid();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
